rv_mem_arbiter: RTL
===================

# rv_mem_arbiter

Two-requester arbiter that shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port. It sits between the RV32I core and the unified instruction/data memory. It grants one transaction at a time, routes the command to memory and returns read data or write acknowledge to the winning port after a fixed memory latency. Data accesses have priority, with a bounded-wait guarantee for fetch.

## Interface

Parameters:
- ADDR_W, 32, byte address width on all ports.
- DATA_W, 32, data width. Must be 32 because the byte enables are 4 bits.
- MEM_LATENCY, 1, cycles from memory command to valid i_mem_rdata. Must be ≥1.
- MAX_WAIT, 4, consecutive unserved cycles after which a pending fetch overrides data priority. Must be ≥1.

Ports:
- i_clk  in  1  clock. All state updates on its rising edge.
- i_rstn  in  1  reset. Asynchronous, active-low.
- i_i_req  in  1  fetch request. Held with a stable address until granted.
- i_i_addr  in  ADDR_W  fetch address.
- o_i_gnt  out  1  fetch command accepted this cycle.
- o_i_rvalid  out  1  fetch data valid.
- o_i_rdata  out  DATA_W  fetch data.
- i_d_req  in  1  load/store request. Held with stable fields until granted.
- i_d_we  in  1  1 = store, 0 = load.
- i_d_addr  in  ADDR_W  data address.
- i_d_wdata  in  DATA_W  store data.
- i_d_be  in  4  store byte enables.
- o_d_gnt  out  1  data command accepted this cycle.
- o_d_rvalid  out  1  load data valid, or store acknowledge.
- o_d_rdata  out  DATA_W  load data. Content is don't-care on a store ack.
- o_mem_en  out  1  memory command strobe.
- o_mem_we  out  1  memory write.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  DATA_W  memory write data.
- o_mem_be  out  4  memory byte enables.
- i_mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after o_mem_en.

## Operation

FSM states:
- IDLE: no transaction outstanding. A grant may be issued.
- WAIT: a transaction is outstanding. A down-counter cnt is loaded with MEM_LATENCY−1 on grant and decrements each cycle. An owner register records which port was granted (I or D).

Grant rules:
- A grant may be issued in IDLE, or in WAIT when cnt==0 (the response cycle).
- A grant pulses exactly one of o_i_gnt or o_d_gnt, combinationally in the same cycle as the request.
- Arbitration when both requests are high: D wins, unless starve==MAX_WAIT, in which case I wins.
- When only one request is high, that port wins.

Command path:
- o_mem_en equals (o_i_gnt | o_d_gnt).
- o_mem_addr, o_mem_we, o_mem_wdata and o_mem_be are muxed combinationally from the winning port.
- On a fetch grant: o_mem_we=0 and o_mem_be=4'hF.

Response path:
- In WAIT with cnt==0, the rvalid of the owner port is asserted for exactly one cycle.
- o_i_rdata and o_d_rdata both carry i_mem_rdata combinationally.
- After the response cycle, the FSM goes to WAIT if a new grant was issued in that cycle, otherwise to IDLE.

Starvation counter (starve):
- Range 0..MAX_WAIT.
- Increments, saturating, in each cycle that i_i_req=1 and o_i_gnt=0.
- Clears to 0 on o_i_gnt, or in any cycle that i_i_req=0.

Requester behaviour:
- A requester that drops req before its grant is simply not served. This is not an error.

## Timing

- Reset asserted (async, any state, including mid-transaction):
  - FSM goes to IDLE; cnt=0; starve=0; owner=I.
  - All rvalids deassert immediately, and the pending response is discarded.
  - Grant outputs and o_mem_en are 0 while i_rstn=0, regardless of req.
- Reset value of every output: 0. The exceptions are the rdata outputs, which follow i_mem_rdata.
- Grant latency: 0 cycles. A request seen in IDLE is granted in the same cycle.
- Response latency: rvalid is asserted exactly MEM_LATENCY cycles after the grant cycle.
- Throughput:
  - One transaction per MEM_LATENCY cycles.
  - With MEM_LATENCY=1, back-to-back grants occur every cycle.
- Simultaneous events: in the response cycle, rvalid for the old owner and a grant to either port may both be asserted. The owner register updates at the clock edge that ends that cycle.
- Fetch wait bound: a continuously requesting fetch port is granted within MAX_WAIT+1 grant opportunities.

## Test plan

- **Reset and idle.** Assert i_rstn=0 mid-WAIT with MEM_LATENCY=2 and a load outstanding → o_d_rvalid never pulses for that load. After release, all outputs are 0 and the FSM is idle.
- **Single load.** MEM_LATENCY=2, i_d_req with addr 0x100 at cycle T → o_d_gnt=1, o_mem_en=1, o_mem_addr=0x100 at T. Memory model returns 0xDEADBEEF at T+2, and o_d_rvalid=1 with o_d_rdata=0xDEADBEEF at T+2 only.
- **Store path.** Store with wdata=0x12345678 and be=4'b0011 → o_mem_we=1, o_mem_be=4'b0011, o_mem_wdata=0x12345678 in the grant cycle. o_d_rvalid ack arrives MEM_LATENCY cycles later, and o_i_rvalid stays 0.
- **Priority.** MEM_LATENCY=1, both requests high at T → o_d_gnt at T, o_i_gnt=0. Drop d_req after its grant → o_i_gnt at T+1.
- **Starvation bound.** MEM_LATENCY=1, MAX_WAIT=4, d_req and i_req held high continuously → 4 data grants, then an o_i_gnt on the 5th cycle. starve returns to 0 afterwards and data regains priority.
- **Back-to-back with overlap.** MEM_LATENCY=3, fetch granted at T and a load requested from T+1 → load granted at T+3. That cycle shows o_i_rvalid=1 and o_d_gnt=1 simultaneously, and o_d_rvalid follows at T+6.

Source files
------------

// File: rtl/rv_mem_arbiter_if.sv
// rv_mem_arbiter_if
//   Bundles the fetch port, the load/store port and the memory command/response
//   signals that pass through rv_mem_arbiter. Signal names are kept identical
//   to the original flat ports so existing wiring maps one-to-one.
//
//   slave  : view used by the arbiter (requests and memory read data in,
//            grants/responses and memory command out).
//   master : view used by the surrounding core/memory/testbench.
//
//   Fetch port    : i_i_req, i_i_addr -> o_i_gnt, o_i_rvalid, o_i_rdata
//   Data port     : i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be
//                   -> o_d_gnt, o_d_rvalid, o_d_rdata
//   Memory port   : o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
//                   <- i_mem_rdata
interface rv_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  // Instruction-fetch port
  logic              i_i_req;
  logic [ADDR_W-1:0] i_i_addr;
  logic              o_i_gnt;
  logic              o_i_rvalid;
  logic [DATA_W-1:0] o_i_rdata;

  // Load/store port
  logic              i_d_req;
  logic              i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic [3:0]        i_d_be;
  logic              o_d_gnt;
  logic              o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;

  // Shared memory port
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [3:0]        o_mem_be;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_i_req, i_i_addr,
    output o_i_gnt, o_i_rvalid, o_i_rdata,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
    output o_d_gnt, o_d_rvalid, o_d_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    input  i_mem_rdata
  );

  modport master (
    output i_i_req, i_i_addr,
    input  o_i_gnt, o_i_rvalid, o_i_rdata,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
    input  o_d_gnt, o_d_rvalid, o_d_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    output i_mem_rdata
  );

endinterface

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter
//   Shares one single-port synchronous memory between the RV32I core's
//   instruction-fetch port and its load/store port. One transaction is in
//   flight at a time; the response (read data or store acknowledge) is
//   returned to the granted port MEM_LATENCY cycles after its grant.
//   Data accesses win ties, except that a fetch that has been left waiting
//   for MAX_WAIT consecutive cycles wins the next grant opportunity.
//
// Parameters
//   ADDR_W      byte address width
//   DATA_W      data width (32; byte enables are 4 bits)
//   MEM_LATENCY memory command to read data latency, >= 1
//   MAX_WAIT    fetch starvation limit in cycles, >= 1
//
// Ports
//   i_clk   rising-edge clock
//   i_rstn  asynchronous active-low reset
//   bus     rv_mem_arbiter_if.slave: fetch port, load/store port, memory port
module rv_mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MAX_WAIT    = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  rv_mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned STV_W = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(MAX_WAIT);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  state_t           state,  state_n;
  owner_t           owner,  owner_n;
  logic [CNT_W-1:0] cnt,    cnt_n;
  logic [STV_W-1:0] starve, starve_n;

  logic rsp;        // response cycle of the outstanding transaction
  logic opp;        // a grant may be issued this cycle
  logic i_wins;     // fetch would win arbitration if granted now
  logic gnt_i;
  logic gnt_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  always_comb begin
    rsp    = (state == ST_WAIT) && (cnt == '0);
    // Gating with i_rstn keeps grants and o_mem_en low throughout reset.
    opp    = i_rstn && ((state == ST_IDLE) || rsp);
    i_wins = bus.i_i_req && (!bus.i_d_req || (starve == STARVE_MAX));
    gnt_i  = opp && i_wins;
    gnt_d  = opp && bus.i_d_req && !i_wins;
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= ST_IDLE;
      owner  <= OWN_I;
      cnt    <= '0;
      starve <= '0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      cnt    <= cnt_n;
      starve <= starve_n;
    end
  end

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_n  = state;
    owner_n  = owner;
    cnt_n    = cnt;
    starve_n = starve;

    unique case (state)
      ST_IDLE: begin
        if (gnt_i || gnt_d) begin
          state_n = ST_WAIT;
          cnt_n   = CNT_LOAD;
          owner_n = gnt_d ? OWN_D : OWN_I;
        end
      end
      ST_WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (gnt_i || gnt_d) begin
          // Response cycle doubles as the next grant cycle.
          cnt_n   = CNT_LOAD;
          owner_n = gnt_d ? OWN_D : OWN_I;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (!bus.i_i_req || gnt_i) begin
      starve_n = '0;
    end else if (starve != STARVE_MAX) begin
      starve_n = starve + STV_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Command path: idle command fields are driven to zero
  // --------------------------------------------------------------------------
  always_comb begin
    bus.o_mem_we    = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    bus.o_mem_be    = '0;
    if (gnt_d) begin
      bus.o_mem_we    = bus.i_d_we;
      bus.o_mem_addr  = bus.i_d_addr;
      bus.o_mem_wdata = bus.i_d_wdata;
      bus.o_mem_be    = bus.i_d_be;
    end else if (gnt_i) begin
      bus.o_mem_addr  = bus.i_i_addr;
      bus.o_mem_be    = '1;
    end
  end

  assign bus.o_mem_en = gnt_i | gnt_d;
  assign bus.o_i_gnt  = gnt_i;
  assign bus.o_d_gnt  = gnt_d;

  // --------------------------------------------------------------------------
  // Response path
  // --------------------------------------------------------------------------
  assign bus.o_i_rvalid = rsp && (owner == OWN_I);
  assign bus.o_d_rvalid = rsp && (owner == OWN_D);
  assign bus.o_i_rdata  = bus.i_mem_rdata;
  assign bus.o_d_rdata  = bus.i_mem_rdata;

endmodule
